// File: rtl/sync_bus_qualifier.sv
// sync_bus_qualifier
// Debounces a bus that has already crossed into the clk domain through a
// multi-bit capture synchronizer. Bits of such a bus can resolve on
// different cycles, so transient mixed old/new values are possible. A new
// value is committed only after it has been sampled identically for
// STABLE_CYCLES consecutive edges. Each commit produces a one-cycle change
// pulse plus per-bit rise/fall masks.
//
// Ports:
//   clk        destination-domain clock
//   resetn     async active-low reset (deassertion already synchronized)
//   dat_in     synchronized bus from the synchronizer output
//   hold       blocks commits while high; sampling and run counting continue
//   dat_out    last committed value
//   changed    one-cycle pulse after a commit edge
//   rise_mask  bits that went 0->1 in the commit (zero when changed=0)
//   fall_mask  bits that went 1->0 in the commit (zero when changed=0)
//   stable     run counter saturated and candidate equals dat_out
//
// Parameters: WIDTH >= 1, STABLE_CYCLES >= 1.
module sync_bus_qualifier #(
    parameter int unsigned      WIDTH         = 16,
    parameter int unsigned      STABLE_CYCLES = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE   = '0
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] dat_in,
    input  logic             hold,
    output logic [WIDTH-1:0] dat_out,
    output logic             changed,
    output logic [WIDTH-1:0] rise_mask,
    output logic [WIDTH-1:0] fall_mask,
    output logic             stable
);

    // Counter wide enough to hold 0..STABLE_CYCLES, never narrower than 1 bit.
    localparam int unsigned     RUN_W   = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CYCLES);

    logic [WIDTH-1:0] cand;
    logic [RUN_W-1:0] run;
    logic [RUN_W-1:0] run_next;
    logic             commit;

    // Run-length of identical samples; a differing sample restarts at 1.
    always_comb begin
        run_next = RUN_W'(1);
        commit   = 1'b0;
        if (dat_in == cand) begin
            run_next = (run == RUN_MAX) ? RUN_MAX : run + RUN_W'(1);
        end
        commit = (run_next == RUN_MAX) && (dat_in != dat_out) && !hold;
    end

    // Sample, count and commit; reset leaves the block already qualified
    // on RESET_VALUE so a matching input produces no pulse.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cand      <= RESET_VALUE;
            run       <= RUN_MAX;
            dat_out   <= RESET_VALUE;
            changed   <= 1'b0;
            rise_mask <= '0;
            fall_mask <= '0;
        end else begin
            cand <= dat_in;
            run  <= run_next;
            if (commit) begin
                dat_out   <= dat_in;
                changed   <= 1'b1;
                rise_mask <= dat_in & ~dat_out;
                fall_mask <= ~dat_in & dat_out;
            end else begin
                changed   <= 1'b0;
                rise_mask <= '0;
                fall_mask <= '0;
            end
        end
    end

    // Combinational status from registers only.
    assign stable = (run == RUN_MAX) && (cand == dat_out);

endmodule

// File: tb/tb_sync_bus_qualifier.sv
module tb_sync_bus_qualifier;

    typedef struct {
        string       tag;
        logic [15:0] dat;
        logic        chg;
        logic [15:0] rise;
        logic [15:0] fall;
        logic        stb;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [15:0] dat_in = '0;
    logic        hold = 1'b0;
    logic [15:0] dat_out;
    logic        changed;
    logic [15:0] rise_mask;
    logic [15:0] fall_mask;
    logic        stable;

    logic [15:0] dat_in1 = '0;
    logic        hold1 = 1'b0;
    logic [15:0] dat_out1;
    logic        changed1;
    logic [15:0] rise_mask1;
    logic [15:0] fall_mask1;
    logic        stable1;

    int passed = 0;
    int total  = 0;
    exp_t sb_q[$];

    sync_bus_qualifier #(.WIDTH(16), .STABLE_CYCLES(4), .RESET_VALUE(16'h0000)) dut (
        .clk(clk), .resetn(resetn), .dat_in(dat_in), .hold(hold),
        .dat_out(dat_out), .changed(changed), .rise_mask(rise_mask),
        .fall_mask(fall_mask), .stable(stable)
    );

    sync_bus_qualifier #(.WIDTH(16), .STABLE_CYCLES(1), .RESET_VALUE(16'h0000)) dut1 (
        .clk(clk), .resetn(resetn), .dat_in(dat_in1), .hold(hold1),
        .dat_out(dat_out1), .changed(changed1), .rise_mask(rise_mask1),
        .fall_mask(fall_mask1), .stable(stable1)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=running required=finished");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Push expectation, drive one cycle, pop and compare after the edge.
    task automatic step(input bit sel, input logic [15:0] d, input logic h, input string tag,
                        input logic [15:0] e_dat, input logic e_chg, input logic [15:0] e_rise,
                        input logic [15:0] e_fall, input logic e_stb);
        exp_t e;
        sb_q.push_back('{tag, e_dat, e_chg, e_rise, e_fall, e_stb});
        if (sel) begin dat_in1 = d; hold1 = h; end
        else     begin dat_in  = d; hold  = h; end
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        if (sel) begin
            check({e.tag, ".dat"},  dat_out1,   e.dat);
            check({e.tag, ".chg"},  16'(changed1), 16'(e.chg));
            check({e.tag, ".rise"}, rise_mask1, e.rise);
            check({e.tag, ".fall"}, fall_mask1, e.fall);
            check({e.tag, ".stb"},  16'(stable1),  16'(e.stb));
        end else begin
            check({e.tag, ".dat"},  dat_out,    e.dat);
            check({e.tag, ".chg"},  16'(changed),  16'(e.chg));
            check({e.tag, ".rise"}, rise_mask,  e.rise);
            check({e.tag, ".fall"}, fall_mask,  e.fall);
            check({e.tag, ".stb"},  16'(stable),   16'(e.stb));
        end
    endtask

    initial begin
        // Reset state
        #12;
        check("rst.dat", dat_out, 16'h0000);
        check("rst.chg", 16'(changed), 16'h0);
        check("rst.stb", 16'(stable), 16'h1);
        check("rst1.stb", 16'(stable1), 16'h1);
        @(posedge clk); #1;
        resetn = 1'b1;

        // STABLE_CYCLES=1: back-to-back commits, then a fall
        step(1, 16'h0001, 0, "s1_a", 16'h0001, 1, 16'h0001, 16'h0000, 1);
        step(1, 16'h0003, 0, "s1_b", 16'h0003, 1, 16'h0002, 16'h0000, 1);
        step(1, 16'h0003, 0, "s1_c", 16'h0003, 0, 16'h0000, 16'h0000, 1);
        step(1, 16'h0002, 0, "s1_d", 16'h0002, 1, 16'h0000, 16'h0001, 1);
        step(1, 16'h0002, 0, "s1_e", 16'h0002, 0, 16'h0000, 16'h0000, 1);

        // Basic qualification: commit on the 4th edge
        for (int i = 1; i <= 3; i++)
            step(0, 16'h00F0, 0, $sformatf("q_e%0d", i), 16'h0000, 0, 16'h0000, 16'h0000, 0);
        step(0, 16'h00F0, 0, "q_e4", 16'h00F0, 1, 16'h00F0, 16'h0000, 1);
        step(0, 16'h00F0, 0, "q_e5", 16'h00F0, 0, 16'h0000, 16'h0000, 1);

        // Glitch excursion shorter than qualification, then revert
        for (int i = 1; i <= 3; i++)
            step(0, 16'h0F00, 0, $sformatf("g_x%0d", i), 16'h00F0, 0, 16'h0000, 16'h0000, 0);
        for (int i = 1; i <= 3; i++)
            step(0, 16'h00F0, 0, $sformatf("g_r%0d", i), 16'h00F0, 0, 16'h0000, 16'h0000, 0);
        step(0, 16'h00F0, 0, "g_r4", 16'h00F0, 0, 16'h0000, 16'h0000, 1);

        // Skewed transition through a mixed value
        step(0, 16'h0FF0, 0, "sk_mix", 16'h00F0, 0, 16'h0000, 16'h0000, 0);
        for (int i = 1; i <= 3; i++)
            step(0, 16'h0F00, 0, $sformatf("sk_%0d", i), 16'h00F0, 0, 16'h0000, 16'h0000, 0);
        step(0, 16'h0F00, 0, "sk_4", 16'h0F00, 1, 16'h0F00, 16'h00F0, 1);
        step(0, 16'h0F00, 0, "sk_5", 16'h0F00, 0, 16'h0000, 16'h0000, 1);

        // Hold blocks commit; release commits on the same edge
        for (int i = 1; i <= 10; i++)
            step(0, 16'h1234, 1, $sformatf("h_%0d", i), 16'h0F00, 0, 16'h0000, 16'h0000, 0);
        step(0, 16'h1234, 0, "h_rel", 16'h1234, 1, 16'h1034, 16'h0D00, 1);
        step(0, 16'h1234, 0, "h_post", 16'h1234, 0, 16'h0000, 16'h0000, 1);

        // Reset mid-count discards progress
        step(0, 16'hAAAA, 0, "mr_1", 16'h1234, 0, 16'h0000, 16'h0000, 0);
        step(0, 16'hAAAA, 0, "mr_2", 16'h1234, 0, 16'h0000, 16'h0000, 0);
        #2;
        resetn = 1'b0;
        #1;
        check("mr_rst.dat",  dat_out, 16'h0000);
        check("mr_rst.chg",  16'(changed), 16'h0);
        check("mr_rst.rise", rise_mask, 16'h0000);
        check("mr_rst.fall", fall_mask, 16'h0000);
        check("mr_rst.stb",  16'(stable), 16'h1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mr_rst2.dat", dat_out, 16'h0000);
        resetn = 1'b1;
        for (int i = 1; i <= 3; i++)
            step(0, 16'hAAAA, 0, $sformatf("mr_q%0d", i), 16'h0000, 0, 16'h0000, 16'h0000, 0);
        step(0, 16'hAAAA, 0, "mr_q4", 16'hAAAA, 1, 16'hAAAA, 16'h0000, 1);
        step(0, 16'hAAAA, 0, "mr_q5", 16'hAAAA, 0, 16'h0000, 16'h0000, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
